// File: rtl/csr_pkg.sv
// Shared CSR addresses, operation codes, interrupt cause codes and helpers
// for the machine-mode CSR file and its interrupt arbiter.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    typedef enum logic [2:0] {
        CSR_OP_W = 3'b001,
        CSR_OP_S = 3'b010,
        CSR_OP_C = 3'b011
    } csr_op_e;

    localparam logic [4:0] CAUSE_MSI   = 5'd3;
    localparam logic [4:0] CAUSE_MTI   = 5'd7;
    localparam logic [4:0] CAUSE_MEI   = 5'd11;
    localparam logic [4:0] CAUSE_PLAT0 = 5'd16;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // RV32I: MXL=1, extension bit I
    localparam logic [31:0] MISA_VAL = 32'h4000_0100;

    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_REQ  = 1'b1
    } irq_state_e;

    function automatic logic [31:0] mie_mask(input int n);
        return 32'h0000_0888 | (((32'h1 << n) - 32'h1) << 16);
    endfunction

    function automatic logic [31:0] csr_apply(input logic [2:0] op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] wdata);
        case (op)
            CSR_OP_W: return wdata;
            CSR_OP_S: return old_val | wdata;
            CSR_OP_C: return old_val & ~wdata;
            default:  return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_irq_arbiter.sv
// Fixed-priority interrupt encoder: MEI, MSI, MTI, then platform lines
// in ascending order. Purely combinational.
module csr_irq_arbiter
    import csr_pkg::*;
#(
    parameter int NUM_PLAT_IRQ = 4
) (
    input  logic [16+NUM_PLAT_IRQ-1:0] pend_i,
    output logic                       any_o,
    output logic [4:0]                 cause_o
);

    logic unused_pend;
    assign unused_pend = ^{pend_i[15:12], pend_i[10:8], pend_i[6:4], pend_i[2:0]};

    // Lowest-priority candidates are evaluated first so higher ones override.
    always_comb begin
        any_o   = 1'b0;
        cause_o = '0;
        for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
            if (pend_i[16+i]) begin
                any_o   = 1'b1;
                cause_o = CAUSE_PLAT0 + 5'(i);
            end
        end
        if (pend_i[7]) begin
            any_o   = 1'b1;
            cause_o = CAUSE_MTI;
        end
        if (pend_i[3]) begin
            any_o   = 1'b1;
            cause_o = CAUSE_MSI;
        end
        if (pend_i[11]) begin
            any_o   = 1'b1;
            cause_o = CAUSE_MEI;
        end
    end

endmodule

// File: rtl/csr_irq_file.sv
// Machine-mode CSR file with interrupt controller; trap request held until trap_ack,
// trap_req rises 2 cycles after a source edge. CSR_COUNTERS_EN adds mcycle/minstret.
module csr_irq_file
    import csr_pkg::*;
#(
    parameter int          NUM_PLAT_IRQ = 4,
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic [11:0]                                 csr_addr_i,
    input  logic [31:0]                                 csr_wdata_i,
    input  logic                                        csr_wen_i,
    input  logic [2:0]                                  csr_op_i,
    output logic [31:0]                                 csr_rdata_o,
    output logic                                        csr_illegal_o,
    input  logic                                        irq_soft_i,
    input  logic                                        irq_timer_i,
    input  logic                                        irq_ext_i,
    input  logic [(NUM_PLAT_IRQ > 0 ? NUM_PLAT_IRQ : 1)-1:0] irq_plat_i,
    input  logic [31:0]                                 current_pc_i,
    input  logic                                        instr_retire_i,
    output logic                                        trap_req_o,
    output logic [31:0]                                 trap_pc_o,
    input  logic                                        trap_ack_i,
    input  logic                                        mret_exec_i,
    output logic [31:0]                                 mret_pc_o
);

    localparam int          AW       = 16 + NUM_PLAT_IRQ;
    localparam logic [31:0] MIE_MASK = mie_mask(NUM_PLAT_IRQ);

    irq_state_e     state_q, state_d;
    logic [4:0]     cause_q;
    logic           mie_q, mpie_q;
    logic [AW-1:0]  mie_q_bits, mip_q, mip_d;
    logic [31:0]    mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [31:0]    mstatus_rd, wr_val;
    logic           impl, ro, op_ok, wr_en, entry, take, arb_any;
    logic [4:0]     arb_cause;
`ifdef CSR_COUNTERS_EN
    logic [63:0]    mcycle_q, minstret_q;
`else
    logic           unused_retire;
    assign unused_retire = instr_retire_i;
`endif

    always_comb begin
        mstatus_rd                = '0;
        mstatus_rd[12:11]         = 2'b11;
        mstatus_rd[MSTATUS_MPIE]  = mpie_q;
        mstatus_rd[MSTATUS_MIE]   = mie_q;
    end

    always_comb begin
        csr_rdata_o = '0;
        impl        = 1'b1;
        ro          = 1'b0;
        case (csr_addr_i)
            CSR_MSTATUS:   csr_rdata_o = mstatus_rd;
            CSR_MISA:      begin csr_rdata_o = MISA_VAL; ro = 1'b1; end
            CSR_MIE:       csr_rdata_o = 32'(mie_q_bits);
            CSR_MTVEC:     csr_rdata_o = mtvec_q;
            CSR_MSCRATCH:  csr_rdata_o = mscratch_q;
            CSR_MEPC:      csr_rdata_o = mepc_q;
            CSR_MCAUSE:    csr_rdata_o = mcause_q;
            CSR_MIP:       begin csr_rdata_o = 32'(mip_q); ro = 1'b1; end
            CSR_MHARTID:   ro = 1'b1;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    csr_rdata_o = mcycle_q[31:0];
            CSR_MCYCLEH:   csr_rdata_o = mcycle_q[63:32];
            CSR_MINSTRET:  csr_rdata_o = minstret_q[31:0];
            CSR_MINSTRETH: csr_rdata_o = minstret_q[63:32];
            CSR_CYCLE:     begin csr_rdata_o = mcycle_q[31:0];    ro = 1'b1; end
            CSR_CYCLEH:    begin csr_rdata_o = mcycle_q[63:32];   ro = 1'b1; end
            CSR_INSTRET:   begin csr_rdata_o = minstret_q[31:0];  ro = 1'b1; end
            CSR_INSTRETH:  begin csr_rdata_o = minstret_q[63:32]; ro = 1'b1; end
`endif
            default:       impl = 1'b0;
        endcase
    end

    assign csr_illegal_o = !impl || (csr_wen_i && ro);
    assign op_ok  = (csr_op_i == CSR_OP_W) || (csr_op_i == CSR_OP_S) || (csr_op_i == CSR_OP_C);
    assign wr_en  = csr_wen_i && op_ok && impl && !ro;
    assign wr_val = csr_apply(csr_op_i, csr_rdata_o, csr_wdata_i);
    assign entry  = (state_q == IRQ_REQ) && trap_ack_i;

    always_comb begin
        mip_d     = '0;
        mip_d[3]  = irq_soft_i;
        mip_d[7]  = irq_timer_i;
        mip_d[11] = irq_ext_i;
        for (int i = 0; i < NUM_PLAT_IRQ; i++) begin
            mip_d[16+i] = irq_plat_i[i];
        end
    end

    csr_irq_arbiter #(.NUM_PLAT_IRQ(NUM_PLAT_IRQ)) u_arb (
        .pend_i  (mip_q & mie_q_bits),
        .any_o   (arb_any),
        .cause_o (arb_cause)
    );

    assign take = mie_q && arb_any;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IRQ_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IRQ_IDLE: if (take)       state_d = IRQ_REQ;
            IRQ_REQ:  if (trap_ack_i) state_d = IRQ_IDLE;
            default:                  state_d = IRQ_IDLE;
        endcase
    end

    always_comb begin
        trap_req_o = (state_q == IRQ_REQ);
        trap_pc_o  = {mtvec_q[31:2], 2'b00};
        if (mtvec_q[0]) trap_pc_o = {mtvec_q[31:2], 2'b00} + {25'b0, cause_q, 2'b00};
    end

    assign mret_pc_o = mepc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause_q <= '0;
            mip_q   <= '0;
        end else begin
            mip_q <= mip_d;
            if (state_q == IRQ_IDLE && take) cause_q <= arb_cause;
        end
    end

    // Trap entry outranks MRET, which outranks a software write to mstatus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mie_q  <= 1'b0;
            mpie_q <= 1'b0;
        end else if (entry) begin
            mpie_q <= mie_q;
            mie_q  <= 1'b0;
        end else if (mret_exec_i) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (wr_en && csr_addr_i == CSR_MSTATUS) begin
            mie_q  <= wr_val[MSTATUS_MIE];
            mpie_q <= wr_val[MSTATUS_MPIE];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mepc_q   <= '0;
            mcause_q <= '0;
        end else if (entry) begin
            mepc_q   <= {current_pc_i[31:2], 2'b00};
            mcause_q <= {1'b1, 26'b0, cause_q};
        end else if (wr_en) begin
            if (csr_addr_i == CSR_MEPC)   mepc_q   <= {wr_val[31:2], 2'b00};
            if (csr_addr_i == CSR_MCAUSE) mcause_q <= wr_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mie_q_bits <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
        end else if (wr_en) begin
            if (csr_addr_i == CSR_MIE)      mie_q_bits <= wr_val[AW-1:0] & MIE_MASK[AW-1:0];
            if (csr_addr_i == CSR_MTVEC)    mtvec_q    <= {wr_val[31:2], 1'b0, wr_val[0]};
            if (csr_addr_i == CSR_MSCRATCH) mscratch_q <= wr_val;
        end
    end

`ifdef CSR_COUNTERS_EN
    // A write to either half replaces that half and skips the increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (wr_en && csr_addr_i == CSR_MCYCLE)       mcycle_q[31:0]  <= wr_val;
            else if (wr_en && csr_addr_i == CSR_MCYCLEH) mcycle_q[63:32] <= wr_val;
            else                                         mcycle_q        <= mcycle_q + 64'd1;

            if (wr_en && csr_addr_i == CSR_MINSTRET)       minstret_q[31:0]  <= wr_val;
            else if (wr_en && csr_addr_i == CSR_MINSTRETH) minstret_q[63:32] <= wr_val;
            else if (instr_retire_i)                       minstret_q        <= minstret_q + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_csr_irq_file.sv
// Directed bench for csr_irq_file: reset values, CSR ops, arbitration, vectored traps,
// MRET and collision priorities, async reset mid-request, optional counters.
module tb_csr_irq_file;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic        csr_wen = 1'b0;
    logic [2:0]  csr_op = 3'b001;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        irq_soft = 1'b0, irq_timer = 1'b0, irq_ext = 1'b0;
    logic [3:0]  irq_plat = '0;
    logic [31:0] current_pc = '0;
    logic        instr_retire = 1'b0;
    logic        trap_req;
    logic [31:0] trap_pc;
    logic        trap_ack = 1'b0;
    logic        mret_exec = 1'b0;
    logic [31:0] mret_pc;

    int checks = 0;
    int errors = 0;

    csr_irq_file #(.NUM_PLAT_IRQ(4), .MTVEC_RESET(32'h0000_0000)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .csr_addr_i     (csr_addr),
        .csr_wdata_i    (csr_wdata),
        .csr_wen_i      (csr_wen),
        .csr_op_i       (csr_op),
        .csr_rdata_o    (csr_rdata),
        .csr_illegal_o  (csr_illegal),
        .irq_soft_i     (irq_soft),
        .irq_timer_i    (irq_timer),
        .irq_ext_i      (irq_ext),
        .irq_plat_i     (irq_plat),
        .current_pc_i   (current_pc),
        .instr_retire_i (instr_retire),
        .trap_req_o     (trap_req),
        .trap_pc_o      (trap_pc),
        .trap_ack_i     (trap_ack),
        .mret_exec_i    (mret_exec),
        .mret_pc_o      (mret_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        csr_wen  = 1'b0;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d, input logic [2:0] op);
        csr_addr  = a;
        csr_wdata = d;
        csr_op    = op;
        csr_wen   = 1'b1;
        tick();
        csr_wen   = 1'b0;
        csr_op    = 3'b001;
    endtask

    initial begin
        #12;
        chk_csr("rst_mstatus_async", 12'h300, 32'h0000_1800);
        check("rst_trap_req", {31'b0, trap_req}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_csr("rst_mie",      12'h304, 32'h0);
        chk_csr("rst_mip",      12'h344, 32'h0);
        chk_csr("rst_mtvec",    12'h305, 32'h0);
        chk_csr("rst_mepc",     12'h341, 32'h0);
        chk_csr("rst_mcause",   12'h342, 32'h0);
        chk_csr("rst_mscratch", 12'h340, 32'h0);
        chk_csr("rst_mhartid",  12'hF14, 32'h0);

        // Illegal accesses
        chk_csr("unimpl_rdata", 12'h7C0, 32'h0);
        check("unimpl_illegal", {31'b0, csr_illegal}, 32'h1);
        csr_addr = 12'h344; csr_wdata = 32'hFFFF_FFFF; csr_op = 3'b001; csr_wen = 1'b1;
        #1;
        check("mip_wr_illegal", {31'b0, csr_illegal}, 32'h1);
        tick();
        csr_wen = 1'b0;
        chk_csr("mip_unchanged", 12'h344, 32'h0);
        chk_csr("mie_legal_rd", 12'h304, 32'h0);
        check("mie_not_illegal", {31'b0, csr_illegal}, 32'h0);

        // Writable-bit masks
        csr_wr(12'h300, 32'hFFFF_FFFF, 3'b001);
        chk_csr("mstatus_mask", 12'h300, 32'h0000_1888);
        csr_wr(12'h300, 32'hFFFF_FFFF, 3'b011);
        chk_csr("mstatus_clr", 12'h300, 32'h0000_1800);
        csr_wr(12'h304, 32'hFFFF_FFFF, 3'b001);
        chk_csr("mie_mask", 12'h304, 32'h000F_0888);

        // Arbitration: timer and external together, external wins
        csr_wr(12'h304, 32'h0000_0888, 3'b001);
        csr_wr(12'h300, 32'h0000_0008, 3'b010);
        current_pc = 32'h0000_2003;
        irq_timer = 1'b1;
        irq_ext   = 1'b1;
        tick();
        check("arb_req_lat1", {31'b0, trap_req}, 32'h0);
        tick();
        check("arb_req_lat2", {31'b0, trap_req}, 32'h1);
        check("arb_trap_pc", trap_pc, 32'h0);
        chk_csr("arb_mip", 12'h344, 32'h0000_0880);
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        check("arb_req_drop", {31'b0, trap_req}, 32'h0);
        chk_csr("arb_mcause",  12'h342, 32'h8000_000B);
        chk_csr("arb_mepc",    12'h341, 32'h0000_2000);
        chk_csr("arb_mstatus", 12'h300, 32'h0000_1880);
        irq_timer = 1'b0;
        irq_ext   = 1'b0;
        tick();
        tick();
        check("no_reentry", {31'b0, trap_req}, 32'h0);

        // MRET
        mret_exec = 1'b1;
        #1;
        check("mret_pc", mret_pc, 32'h0000_2000);
        tick();
        mret_exec = 1'b0;
        chk_csr("mret_mstatus", 12'h300, 32'h0000_1888);
        tick();
        check("mret_no_req", {31'b0, trap_req}, 32'h0);

        // Vectored mode with platform line 2
        csr_wr(12'h305, 32'h0000_1003, 3'b001);
        chk_csr("mtvec_bit1", 12'h305, 32'h0000_1001);
        csr_wr(12'h304, 32'h0004_0000, 3'b001);
        irq_plat = 4'b0100;
        tick();
        irq_plat = 4'b0000;
        check("vec_req_lat1", {31'b0, trap_req}, 32'h0);
        tick();
        check("vec_req", {31'b0, trap_req}, 32'h1);
        check("vec_trap_pc", trap_pc, 32'h0000_1048);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("vec_hold_req", {31'b0, trap_req}, 32'h1);
            check("vec_hold_pc", trap_pc, 32'h0000_1048);
        end
        csr_wr(12'h304, 32'h0, 3'b001);
        check("vec_frozen_req", {31'b0, trap_req}, 32'h1);
        check("vec_frozen_pc", trap_pc, 32'h0000_1048);

        // Ack colliding with mepc write and MRET
        current_pc = 32'h0000_3006;
        trap_ack  = 1'b1;
        mret_exec = 1'b1;
        csr_wr(12'h341, 32'hDEAD_BEEF, 3'b001);
        trap_ack  = 1'b0;
        mret_exec = 1'b0;
        check("coll_req_drop", {31'b0, trap_req}, 32'h0);
        chk_csr("coll_mepc",    12'h341, 32'h0000_3004);
        chk_csr("coll_mcause",  12'h342, 32'h8000_0012);
        chk_csr("coll_mstatus", 12'h300, 32'h0000_1880);

        mret_exec = 1'b1;
        tick();
        mret_exec = 1'b0;
        chk_csr("mret2_mstatus", 12'h300, 32'h0000_1888);

        // Ack while idle is ignored
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        chk_csr("idle_ack_mcause",  12'h342, 32'h8000_0012);
        chk_csr("idle_ack_mstatus", 12'h300, 32'h0000_1888);
        chk_csr("idle_ack_mepc",    12'h341, 32'h0000_3004);

        // Set / clear / no-op write codes
        csr_wr(12'h340, 32'hA5A5_0000, 3'b001);
        csr_wr(12'h340, 32'h0000_00FF, 3'b010);
        chk_csr("mscratch_set", 12'h340, 32'hA5A5_00FF);
        csr_wr(12'h340, 32'hA500_0000, 3'b011);
        chk_csr("mscratch_clr", 12'h340, 32'h00A5_00FF);
        csr_wr(12'h340, 32'hFFFF_FFFF, 3'b100);
        chk_csr("mscratch_noop", 12'h340, 32'h00A5_00FF);

        // MRET beats a same-cycle mstatus write
        mret_exec = 1'b1;
        csr_wr(12'h300, 32'h0, 3'b001);
        mret_exec = 1'b0;
        chk_csr("mret_vs_wr", 12'h300, 32'h0000_1888);

        // Software interrupt, then async reset while requesting
        csr_wr(12'h304, 32'h0000_0008, 3'b001);
        irq_soft = 1'b1;
        tick();
        tick();
        check("soft_req", {31'b0, trap_req}, 32'h1);
        check("soft_trap_pc", trap_pc, 32'h0000_100C);
        #2;
        reset_n  = 1'b0;
        csr_addr = 12'h300;
        #1;
        check("arst_req", {31'b0, trap_req}, 32'h0);
        check("arst_mstatus", csr_rdata, 32'h0000_1800);
        irq_soft = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_csr("arst_mtvec", 12'h305, 32'h0);

`ifdef CSR_COUNTERS_EN
        csr_wr(12'hB00, 32'hFFFF_FFFF, 3'b001);
        csr_wr(12'hB80, 32'h0, 3'b001);
        chk_csr("mcycleh_pre", 12'hB80, 32'h0);
        tick();
        chk_csr("mcycleh_carry", 12'hB80, 32'h1);
        chk_csr("cycleh_shadow", 12'hC80, 32'h1);
        csr_wr(12'hB02, 32'h0, 3'b001);
        csr_wr(12'hB82, 32'h0, 3'b001);
        instr_retire = 1'b1;
        tick();
        tick();
        tick();
        instr_retire = 1'b0;
        chk_csr("minstret_cnt", 12'hB02, 32'h3);
        csr_addr = 12'hC00; csr_op = 3'b001; csr_wen = 1'b1;
        #1;
        check("cycle_ro_illegal", {31'b0, csr_illegal}, 32'h1);
        csr_wen = 1'b0;
`else
        chk_csr("mcycle_absent", 12'hB00, 32'h0);
        check("mcycle_illegal", {31'b0, csr_illegal}, 32'h1);
        chk_csr("cycleh_absent", 12'hC80, 32'h0);
        check("cycleh_illegal", {31'b0, csr_illegal}, 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
